// File: rtl/data_sram_bridge_if.sv
// SRAM-like data bus between the ME-stage bridge and the data memory.
// The master issues req/addr/wdata; the slave answers with addr_ok, data_ok and rdata.
interface data_sram_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_bridge.sv
// ME-stage to SRAM-like bus bridge: one outstanding access, pipeline stalled until it completes,
// byte strobes and lane-replicated store data, optional timeout abort with a bus_err pulse.
module data_sram_bridge #(
  parameter int WAIT_LIMIT = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_en,
  input  logic               mem_wr,
  input  logic [1:0]         mem_size,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_stall,
  output logic               addr_err,
  output logic               bus_err,
  data_sram_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // The counter only ever needs to reach WAIT_LIMIT-1.
  localparam int CNT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               req_q;
  logic               wr_q;
  logic [1:0]         size_q;
  logic [31:0]        addr_q;
  logic [3:0]         wstrb_q;
  logic [31:0]        wdata_q;

  logic               aligned;
  logic               issue;
  logic               timeout_hit;
  logic [3:0]         strb;
  logic [31:0]        wdata_rep;
  logic [31:0]        addr_out;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    aligned   = 1'b1;
    strb      = 4'b1111;
    wdata_rep = mem_wdata;
    case (mem_size)
      2'd0: begin
        strb      = 4'b0001 << mem_addr[1:0];
        wdata_rep = {4{mem_wdata[7:0]}};
      end
      2'd1: begin
        aligned   = ~mem_addr[0];
        strb      = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{mem_wdata[15:0]}};
      end
      default: aligned = (mem_addr[1:0] == 2'b00);
    endcase
  end

  // Word (and reserved size 3) accesses present a word-aligned address.
  assign addr_out    = mem_size[1] ? {mem_addr[31:2], 2'b00} : mem_addr;
  assign issue       = mem_en & aligned;
  assign addr_err    = mem_en & ~aligned;
  assign mem_stall   = (state == REQ) | (state == WAIT) | ((state == IDLE) & issue);
  assign timeout_hit = (WAIT_LIMIT != 0) && (count == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wstrb_q   <= 4'd0;
      wdata_q   <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (issue) begin
            req_q   <= 1'b1;
            wr_q    <= mem_wr;
            size_q  <= mem_size;
            addr_q  <= addr_out;
            wstrb_q <= mem_wr ? strb : 4'b0000;
            wdata_q <= wdata_rep;
            state   <= REQ;
          end
        end
        REQ: begin
          count <= count + CNT_W'(1);
          // Completion wins over a timeout landing on the same cycle.
          if (bus.data_addr_ok && bus.data_data_ok) begin
            req_q <= 1'b0;
            if (!wr_q) mem_rdata <= bus.data_rdata;
            state <= DONE;
          end else if (timeout_hit) begin
            req_q   <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end else if (bus.data_addr_ok) begin
            req_q <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          count <= count + CNT_W'(1);
          if (bus.data_data_ok) begin
            if (!wr_q) mem_rdata <= bus.data_rdata;
            state <= DONE;
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_req   = req_q;
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wstrb = wstrb_q;
  assign bus.data_wdata = wdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: directed vector table, random accesses against
// a latency-arithmetic reference model, and a reset-during-WAIT sequence.
module tb_data_sram_bridge;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_stall, addr_err, bus_err;

  data_sram_bridge_if bus_if ();

  data_sram_bridge #(.WAIT_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          a_lat;   // REQ cycle index carrying addr_ok
    int          d_lat;   // cycles from addr_ok to data_ok
    logic [31:0] rd;
  } req_t;

  typedef struct {
    logic        addr_err;
    int          busy;
    int          req_cnt;
    logic        bus_err;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] daddr;
  } exp_t;

  typedef struct {
    req_t r;
    exp_t e;
  } vec_t;

  typedef struct {
    logic        addr_err;
    logic        stall_issue;
    logic        done_seen;
    int          busy;
    int          req_cnt;
    logic        bus_err;
    logic        bus_err_after;
    logic        req_done;
    logic [31:0] rdata_done;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] daddr;
    logic        dwr;
    logic [1:0]  dsize;
    logic        stable;
  } obs_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: expected outcome from access size, offset and bus latencies.
  function automatic exp_t model(input req_t r);
    exp_t e;
    int   bytes, off, c;
    e = '{default: 0};
    bytes = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
    off   = int'(r.addr[1:0]);
    e.rdata = model_rdata;
    if (off % bytes != 0) begin
      e.addr_err = 1'b1;
      return e;
    end
    for (int k = 0; k < 4; k++) begin
      if (r.wr && k >= off && k < off + bytes) e.wstrb[k] = 1'b1;
      e.wdata[8*k +: 8] = r.wdata[8*(k % bytes) +: 8];
    end
    e.daddr = (bytes == 4) ? {r.addr[31:2], 2'b00} : r.addr;
    c = r.a_lat + r.d_lat;
    if (c >= LIMIT) begin
      e.busy    = LIMIT;
      e.req_cnt = (r.a_lat + 1 < LIMIT) ? r.a_lat + 1 : LIMIT;
      e.bus_err = 1'b1;
    end else begin
      e.busy    = c + 1;
      e.req_cnt = r.a_lat + 1;
      if (!r.wr) model_rdata = r.rd;
    end
    e.rdata = model_rdata;
    return e;
  endfunction

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input int a, input int d, input logic [31:0] rd,
                              input logic aerr, input int busy, input int req, input logic berr,
                              input logic [31:0] rdata, input logic [3:0] strb, input logic [31:0] wd,
                              input logic [31:0] daddr);
    vec_t v;
    v.r = '{wr, size, addr, wdata, a, d, rd};
    v.e = '{aerr, busy, req, berr, rdata, strb, wd, daddr};
    return v;
  endfunction

  // Starts at posedge+1 of an IDLE cycle, returns at posedge+1 of the cycle after the access.
  task automatic run_access(input req_t r, output obs_t o);
    int c;
    o = '{default: 0};
    o.stable = 1'b1;
    mem_en = 1'b1; mem_wr = r.wr; mem_size = r.size; mem_addr = r.addr; mem_wdata = r.wdata;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0;
    #1;
    o.addr_err    = addr_err;
    o.stall_issue = mem_stall;
    @(posedge clk); #1;
    if (o.addr_err) begin
      o.req_done = bus_if.data_req;
      return;
    end
    o.daddr = bus_if.data_addr; o.wstrb = bus_if.data_wstrb; o.wdata = bus_if.data_wdata;
    o.dwr   = bus_if.data_wr;   o.dsize = bus_if.data_size;
    c = r.a_lat + r.d_lat;
    for (int i = 0; i < 300; i++) begin
      bus_if.data_addr_ok = (i == r.a_lat);
      bus_if.data_data_ok = (i == c);
      bus_if.data_rdata   = (i == c) ? r.rd : $urandom;
      #1;
      if (!mem_stall) begin
        o.done_seen = 1'b1;
        break;
      end
      o.busy++;
      if (bus_if.data_req) begin
        o.req_cnt++;
        if (bus_if.data_addr !== o.daddr || bus_if.data_wstrb !== o.wstrb ||
            bus_if.data_wdata !== o.wdata || bus_if.data_wr !== o.dwr || bus_if.data_size !== o.dsize)
          o.stable = 1'b0;
      end
      @(posedge clk); #1;
    end
    o.bus_err    = bus_err;
    o.rdata_done = mem_rdata;
    o.req_done   = bus_if.data_req;
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
    @(posedge clk); #1;
    o.bus_err_after = bus_err;
    o.rdata         = mem_rdata;
  endtask

  task automatic compare_access(input string tag, input req_t r, input exp_t e, input obs_t o);
    check({tag, ".addr_err"}, 32'(o.addr_err), 32'(e.addr_err));
    check({tag, ".stall_issue"}, 32'(o.stall_issue), 32'(!e.addr_err));
    if (e.addr_err) begin
      check({tag, ".no_req"}, 32'(o.req_done), 32'd0);
    end else begin
      check({tag, ".completed"}, 32'(o.done_seen), 32'd1);
      check({tag, ".stall_cycles"}, o.busy, e.busy);
      check({tag, ".req_cycles"}, o.req_cnt, e.req_cnt);
      check({tag, ".bus_err"}, 32'(o.bus_err), 32'(e.bus_err));
      check({tag, ".bus_err_pulse"}, 32'(o.bus_err_after), 32'd0);
      check({tag, ".req_done"}, 32'(o.req_done), 32'd0);
      check({tag, ".rdata_done"}, o.rdata_done, e.rdata);
      check({tag, ".rdata_hold"}, o.rdata, e.rdata);
      check({tag, ".data_addr"}, o.daddr, e.daddr);
      check({tag, ".wstrb"}, 32'(o.wstrb), 32'(e.wstrb));
      check({tag, ".data_wr"}, 32'(o.dwr), 32'(r.wr));
      check({tag, ".data_size"}, 32'(o.dsize), 32'(r.size));
      check({tag, ".stable"}, 32'(o.stable), 32'd1);
      if (r.wr) check({tag, ".wdata"}, o.wdata, e.wdata);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    req_t r;
    exp_t e;
    obs_t o;

    tbl[0]  = mk(0, 2'd2, 32'h1000, 32'h0,        0, 0, 32'hDEADBEEF, 0, 1, 1, 0, 32'hDEADBEEF, 4'b0000, 32'h0,        32'h1000);
    tbl[1]  = mk(1, 2'd0, 32'h1003, 32'h000000A5, 0, 0, 32'h0,        0, 1, 1, 0, 32'hDEADBEEF, 4'b1000, 32'hA5A5A5A5, 32'h1003);
    tbl[2]  = mk(1, 2'd1, 32'h1002, 32'h00001234, 1, 1, 32'h0,        0, 3, 2, 0, 32'hDEADBEEF, 4'b1100, 32'h12341234, 32'h1002);
    tbl[3]  = mk(1, 2'd1, 32'h1001, 32'h00001234, 0, 0, 32'h0,        1, 0, 0, 0, 32'hDEADBEEF, 4'b0000, 32'h0,        32'h0);
    tbl[4]  = mk(0, 2'd2, 32'h2000, 32'h0,        3, 2, 32'h0BADF00D, 0, 6, 4, 0, 32'h0BADF00D, 4'b0000, 32'h0,        32'h2000);
    tbl[5]  = mk(0, 2'd0, 32'h2001, 32'h0,        0, 3, 32'h11223344, 0, 4, 1, 0, 32'h11223344, 4'b0000, 32'h0,        32'h2001);
    tbl[6]  = mk(0, 2'd1, 32'h2003, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h11223344, 4'b0000, 32'h0,        32'h0);
    tbl[7]  = mk(0, 2'd2, 32'h2002, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h11223344, 4'b0000, 32'h0,        32'h0);
    tbl[8]  = mk(1, 2'd2, 32'h3004, 32'hCAFEF00D, 2, 0, 32'h0,        0, 3, 3, 0, 32'h11223344, 4'b1111, 32'hCAFEF00D, 32'h3004);
    tbl[9]  = mk(1, 2'd0, 32'h3000, 32'h1234567F, 0, 1, 32'h0,        0, 2, 1, 0, 32'h11223344, 4'b0001, 32'h7F7F7F7F, 32'h3000);
    tbl[10] = mk(0, 2'd3, 32'h4000, 32'h0,        1, 0, 32'h55AA55AA, 0, 2, 2, 0, 32'h55AA55AA, 4'b0000, 32'h0,        32'h4000);
    tbl[11] = mk(0, 2'd2, 32'h5000, 32'h0,        7, 0, 32'h01020304, 0, 8, 8, 0, 32'h01020304, 4'b0000, 32'h0,        32'h5000);
    tbl[12] = mk(0, 2'd2, 32'h5004, 32'h0,        5, 3, 32'hFFFFFFFF, 0, 8, 6, 1, 32'h01020304, 4'b0000, 32'h0,        32'h5004);
    tbl[13] = mk(1, 2'd1, 32'h6000, 32'hABCD5678, 0, 0, 32'h0,        0, 1, 1, 0, 32'h01020304, 4'b0011, 32'h56785678, 32'h6000);
    tbl[14] = mk(0, 2'd2, 32'h7000, 32'h0,     1000, 0, 32'hEEEEEEEE, 0, 8, 8, 1, 32'h01020304, 4'b0000, 32'h0,        32'h7000);
    tbl[15] = mk(1, 2'd2, 32'h7008, 32'h13579BDF, 0, 0, 32'h0,        0, 1, 1, 0, 32'h01020304, 4'b1111, 32'h13579BDF, 32'h7008);

    rst = 1'b0;
    mem_en = 1'b0; mem_wr = 1'b0; mem_size = 2'd0; mem_addr = '0; mem_wdata = '0;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.data_req", 32'(bus_if.data_req), 32'd0);
    check("reset.data_wstrb", 32'(bus_if.data_wstrb), 32'd0);
    check("reset.data_addr", bus_if.data_addr, 32'd0);
    check("reset.mem_rdata", mem_rdata, 32'd0);
    check("reset.bus_err", 32'(bus_err), 32'd0);
    check("reset.mem_stall", 32'(mem_stall), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_access(tbl[i].r, o);
      compare_access($sformatf("vec%0d", i), tbl[i].r, tbl[i].e, o);
      model_rdata = tbl[i].e.rdata;
    end

    for (int n = 0; n < 200; n++) begin
      r.wr    = 1'($urandom_range(0, 1));
      r.size  = 2'($urandom_range(0, 3));
      r.addr  = $urandom;
      r.wdata = $urandom;
      r.rd    = $urandom;
      if ($urandom_range(0, 9) < 8) begin
        if (r.size == 2'd1) r.addr[0] = 1'b0;
        else if (r.size != 2'd0) r.addr[1:0] = 2'b00;
      end
      r.a_lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 3));
      r.d_lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 3));
      e = model(r);
      run_access(r, o);
      compare_access($sformatf("rand%0d", n), r, e, o);
      if ($urandom_range(0, 3) == 0) begin
        mem_en = 1'b0;
        @(posedge clk); #1;
      end
    end

    // Reset asserted while the bridge waits for data_ok.
    mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_addr = 32'h8000;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0;
    @(posedge clk); #1;
    bus_if.data_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_if.data_addr_ok = 1'b0;
    check("rst_wait.req_low", 32'(bus_if.data_req), 32'd0);
    check("rst_wait.stalled", 32'(mem_stall), 32'd1);
    mem_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_wait.data_req", 32'(bus_if.data_req), 32'd0);
    check("rst_wait.data_wr", 32'(bus_if.data_wr), 32'd0);
    check("rst_wait.data_size", 32'(bus_if.data_size), 32'd0);
    check("rst_wait.data_addr", bus_if.data_addr, 32'd0);
    check("rst_wait.data_wstrb", 32'(bus_if.data_wstrb), 32'd0);
    check("rst_wait.data_wdata", bus_if.data_wdata, 32'd0);
    check("rst_wait.mem_rdata", mem_rdata, 32'd0);
    check("rst_wait.bus_err", 32'(bus_err), 32'd0);
    check("rst_wait.mem_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h99999999;
    #1;
    check("late_ok.stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    bus_if.data_data_ok = 1'b0;
    check("late_ok.mem_rdata", mem_rdata, 32'd0);
    check("late_ok.data_req", 32'(bus_if.data_req), 32'd0);
    model_rdata = '0;

    r = '{1'b0, 2'd2, 32'h9000, 32'h0, 1, 1, 32'h600DF00D};
    e = model(r);
    run_access(r, o);
    compare_access("post_rst", r, e, o);
    mem_en = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
